// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate generator with a valid/ready output register and one skid entry.
// Also keeps a saturating count of accepted instructions with unrecognised opcodes.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       fmt,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   fmt_e            dec_fmt;
   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;
   logic            dec_ill;

   always_comb begin
      dec_fmt = FMT_ILL;
      case (instr[6:0])
         7'b0000011,
         7'b0010011,
         7'b1100111,
         7'b1110011: dec_fmt = FMT_I;
         7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
         7'b0100011: dec_fmt = FMT_S;
         7'b1100011: dec_fmt = FMT_B;
         7'b0110111,
         7'b0010111: dec_fmt = FMT_U;
         7'b1101111: dec_fmt = FMT_J;
         7'b0110011: dec_fmt = FMT_R;
         7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
         default:    dec_fmt = FMT_ILL;
      endcase
   end

   // Every encoding keeps instr[31] as its top bit, so widening to XLEN is a plain sign extension.
   always_comb begin
      dec_imm32 = '0;
      case (dec_fmt)
         FMT_I: dec_imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
         FMT_U: dec_imm32 = {instr[31:12], 12'h000};
         FMT_J: dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
         default: dec_imm32 = '0;
      endcase
   end

   assign dec_imm = XLEN'($signed(dec_imm32));
   assign dec_ill = (dec_fmt == FMT_ILL);

   // Pipeline storage: output register (o_*) and skid register (s_*).
   logic            o_valid, s_valid, rdy_q;
   logic [XLEN-1:0] o_imm, s_imm;
   fmt_e            o_fmt, s_fmt;
   logic            o_ill, s_ill;
   logic [CNT_W-1:0] cnt_q;

   logic in_fire, load_out, skid_load, s_valid_nxt;

   always_comb begin
      in_fire     = in_valid & rdy_q;
      load_out    = ~o_valid | out_ready;
      // in_fire implies an empty skid, so the skid never has to load and drain together.
      skid_load   = in_fire & o_valid & ~out_ready;
      s_valid_nxt = skid_load | (s_valid & ~load_out);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_imm   <= '0;
         o_fmt   <= FMT_R;
         o_ill   <= 1'b0;
         s_valid <= 1'b0;
         s_imm   <= '0;
         s_fmt   <= FMT_R;
         s_ill   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         s_valid <= s_valid_nxt;
         rdy_q   <= ~s_valid_nxt;
         if (load_out) begin
            o_valid <= s_valid | in_fire;
            if (s_valid) begin
               o_imm <= s_imm;
               o_fmt <= s_fmt;
               o_ill <= s_ill;
            end else if (in_fire) begin
               o_imm <= dec_imm;
               o_fmt <= dec_fmt;
               o_ill <= dec_ill;
            end
         end
         if (skid_load) begin
            s_imm <= dec_imm;
            s_fmt <= dec_fmt;
            s_ill <= dec_ill;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (in_fire && dec_ill && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign in_ready    = rdy_q;
   assign out_valid   = o_valid;
   assign imm         = o_imm;
   assign fmt         = o_fmt;
   assign illegal     = o_ill;
   assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate; legal values are 32 and 64.
REQ-002 Parameter CNT_W, default 8, width of the illegal-opcode counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an instruction is offered on instr.
REQ-006 in_ready  output  1  block accepts instr this cycle.
REQ-007 instr  input  32  RV32/RV64 base instruction word.
REQ-008 out_valid  output  1  imm/fmt/illegal hold a valid result.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 imm  output  XLEN  sign-extended immediate.
REQ-011 fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-012 illegal  output  1  opcode not recognised.
REQ-013 illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-014 A transfer occurs on a side when valid and ready are both 1 at a rising clk edge.
REQ-015 Decode on instr[6:0]:
- I: 0000011, 0010011, 1100111, 1110011, plus 0011011 when XLEN=64.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- R: 0110011, plus 0111011 when XLEN=64.
- Anything else is illegal.
REQ-016 Immediate encodings:
- I = sext(instr[31:20]).
- S = sext({instr[31:25], instr[11:7]}).
- B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U = sext({instr[31:12], 12'h000}).
- J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Sign extension is from instr[31] to XLEN bits.
REQ-017 R-format and illegal instructions produce imm=0; illegal also forces fmt=7 and illegal=1. All other formats produce illegal=0.
REQ-018 Latency: a result appears on the outputs exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-019 Storage is an output register plus one skid register, for 2 results maximum.
REQ-020 in_ready is the registered signal (skid register empty), with no combinational path from out_ready.
REQ-021 Output register load rule: it loads when it is empty or out_ready=1. It loads from skid if skid is full, else from the accepted input.
REQ-022 Skid register load rule: it loads the accepted input when the output register holds data and out_ready=0.
REQ-023 Results leave the block in acceptance order; none is dropped or duplicated.
REQ-024 imm, fmt and illegal hold stable while out_valid=1 and out_ready=0.
REQ-025 Full throughput: with out_ready held at 1, one result per cycle is sustained.
REQ-026 illegal_cnt increments by 1 on each input transfer whose opcode is illegal, and saturates at all-ones without wrapping.
REQ-027 The counter update is tied to input acceptance, not output delivery.
REQ-028 Simultaneous output drain and input accept with full skid: the output register takes the skid entry and the skid register takes the new input. This case cannot arise while in_ready=0, so in_ready=0 blocks it.

Reset
REQ-029 reset=1 asynchronously clears both stages and sets illegal_cnt=0.
REQ-030 While reset=1, outputs are: out_valid=0, in_ready=0, imm=0, fmt=0, illegal=0.
REQ-031 On the first clk edge after reset deasserts, in_ready=1.
REQ-032 Reset asserted mid-operation discards all buffered results without emitting them.

Verification
REQ-033 instr=0xFFC12083 (lw x1,-4(x2)), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFC, fmt=1, illegal=0.
REQ-034 B, U and J immediates, each checked one cycle after acceptance, also with XLEN=64:
- 0xFE000CE3 -> imm=0xFFFFFFF8, fmt=3.
- 0x123450B7 -> imm=0x12345000, fmt=4.
- 0x0010006F -> imm=0x00000800, fmt=5.
- XLEN=64 with 0xFE000CE3 -> imm=0xFFFFFFFFFFFFFFF8.
REQ-035 instr=0x0000007F accepted 3 times -> illegal=1, fmt=7, imm=0, illegal_cnt=3. With CNT_W=2 and 5 such instructions, illegal_cnt holds at 3.
REQ-036 out_ready=0 with in_valid=1 for 3 back-to-back instructions A, B, C:
- A goes to the output register, B to skid, and in_ready drops to 0; C is held by the source.
- Raising out_ready delivers A, B, C in order, one per cycle, none lost.
REQ-037 Assert reset while 2 results are buffered -> out_valid=0 immediately (asynchronously), illegal_cnt=0, and no stale result appears after release.
REQ-038 Random valid/ready stimulus against a reference decode model -> output sequence equals input sequence, and REQ-024 is never violated.
